// File: rtl/fft_input_loader_pkg.sv
// Shared definitions for the FFT loader/unloader slice: core geometry and loader state encoding.
package fft_input_loader_pkg;

  localparam int unsigned FFT_N_POINTS = 2048;
  localparam int unsigned FFT_ADDR_W   = 9;
  localparam int unsigned FFT_DATA_W   = 16;
  localparam int unsigned FFT_N_BANK   = 4;
  localparam int unsigned FFT_BANK_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_START,
    ST_WAIT
  } loader_state_e;

  // States in which the loader is willing to take stream samples.
  function automatic logic accepts_samples(input loader_state_e s);
    return (s == ST_IDLE) || (s == ST_LOAD);
  endfunction

endpackage

// File: rtl/fft_input_loader_addr_map.sv
// Combinational sample index -> (bank, word address) mapper for the four RAM_A banks.
// Define FFT_LOADER_BITREV_EN to bit-reverse the index before mapping.
module fft_addr_map
  import fft_input_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = FFT_ADDR_W
) (
  input  logic [ADDR_W+FFT_BANK_W-1:0] n_i,
  output logic [FFT_BANK_W-1:0]        bank_o,
  output logic [ADDR_W-1:0]            addr_o
);

  localparam int unsigned IDX_W = ADDR_W + FFT_BANK_W;

  logic [IDX_W-1:0] idx;

`ifdef FFT_LOADER_BITREV_EN
  always_comb begin
    idx = '0;
    for (int i = 0; i < IDX_W; i++) begin
      idx[i] = n_i[IDX_W-1-i];
    end
  end
`else
  assign idx = n_i;
`endif

  // Low bits interleave consecutive indices across banks.
  assign bank_o = idx[FFT_BANK_W-1:0];
  assign addr_o = idx[IDX_W-1:FFT_BANK_W];

endmodule

// File: rtl/fft_input_loader.sv
// Streams one frame of real samples into the FFT core's four RAM_A banks, starts the core and stalls until done.
// Optional FFT_LOADER_BITREV_EN (in fft_addr_map) writes frames in bit-reversed order.
module fft_input_loader
  import fft_input_loader_pkg::*;
#(
  parameter int unsigned DATA_W   = FFT_DATA_W,
  parameter int unsigned ADDR_W   = FFT_ADDR_W,
  parameter int unsigned N_POINTS = FFT_N_POINTS
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iVALID,
  input  logic [DATA_W-1:0] iSAMPLE,
  output logic              oREADY,
  input  logic              iFFT_RDY,
  output logic [DATA_W-1:0] oDATA,
  output logic [ADDR_W-1:0] oADDR_WR_0,
  output logic [ADDR_W-1:0] oADDR_WR_1,
  output logic [ADDR_W-1:0] oADDR_WR_2,
  output logic [ADDR_W-1:0] oADDR_WR_3,
  output logic              oWE_0,
  output logic              oWE_1,
  output logic              oWE_2,
  output logic              oWE_3,
  output logic              oSTART,
  output logic              oBUSY,
  output logic [7:0]        oFRAME_CNT
);

  localparam int unsigned IDX_W = ADDR_W + FFT_BANK_W;

  loader_state_e           state_q, state_d;
  logic [IDX_W-1:0]        n_q;
  logic                    ready_q;
  logic                    start_q;
  logic                    busy_q;
  logic [DATA_W-1:0]       data_q;
  logic [ADDR_W-1:0]       addr_q [FFT_N_BANK];
  logic [FFT_N_BANK-1:0]   we_q;
  logic [7:0]              frame_q;

  logic                    accept_c;
  logic                    last_c;
  logic [FFT_BANK_W-1:0]   bank_c;
  logic [ADDR_W-1:0]       waddr_c;

  assign accept_c = iVALID & ready_q;
  assign last_c   = (n_q == IDX_W'(N_POINTS - 1));

  fft_addr_map #(.ADDR_W(ADDR_W)) u_addr_map (
    .n_i    (n_q),
    .bank_o (bank_c),
    .addr_o (waddr_c)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept_c) state_d = ST_LOAD;
      ST_LOAD:  if (accept_c && last_c) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (iFFT_RDY) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Ready drops with the final accept but rises only after a full cycle back in IDLE.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      ready_q <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      we_q    <= '0;
      frame_q <= '0;
      for (int b = 0; b < FFT_N_BANK; b++) begin
        addr_q[b] <= '0;
      end
    end else begin
      state_q <= state_d;
      ready_q <= accepts_samples(state_q) && accepts_samples(state_d);
      start_q <= (state_d == ST_START);
      busy_q  <= (state_d == ST_START) || (state_d == ST_WAIT);
      we_q    <= '0;
      if (accept_c) begin
        n_q             <= n_q + IDX_W'(1);
        data_q          <= iSAMPLE;
        we_q[bank_c]    <= 1'b1;
        addr_q[bank_c]  <= waddr_c;
      end
      if ((state_q == ST_WAIT) && iFFT_RDY) begin
        frame_q <= frame_q + 8'd1;
        n_q     <= '0;
      end
    end
  end

  assign oREADY     = ready_q;
  assign oSTART     = start_q;
  assign oBUSY      = busy_q;
  assign oDATA      = data_q;
  assign oFRAME_CNT = frame_q;
  assign oWE_0      = we_q[0];
  assign oWE_1      = we_q[1];
  assign oWE_2      = we_q[2];
  assign oWE_3      = we_q[3];
  assign oADDR_WR_0 = addr_q[0];
  assign oADDR_WR_1 = addr_q[1];
  assign oADDR_WR_2 = addr_q[2];
  assign oADDR_WR_3 = addr_q[3];

endmodule

// File: tb/tb_fft_input_loader.sv
// Self-checking bench for fft_input_loader; honours FFT_LOADER_BITREV_EN for the expected mapping.
module tb_fft_input_loader;

  logic        iCLK = 1'b0;
  logic        iRESET = 1'b1;
  logic        iVALID = 1'b0;
  logic [15:0] iSAMPLE = '0;
  logic        iFFT_RDY = 1'b0;
  logic        oREADY;
  logic [15:0] oDATA;
  logic [8:0]  oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;
  logic        oWE_0, oWE_1, oWE_2, oWE_3;
  logic        oSTART, oBUSY;
  logic [7:0]  oFRAME_CNT;

  int checks = 0;
  int failures = 0;
  int m_n = 0;
  int starts = 0;
  int frames = 0;
  int guard;

  always #5 iCLK = ~iCLK;

  fft_input_loader dut (
    .iCLK       (iCLK),
    .iRESET     (iRESET),
    .iVALID     (iVALID),
    .iSAMPLE    (iSAMPLE),
    .oREADY     (oREADY),
    .iFFT_RDY   (iFFT_RDY),
    .oDATA      (oDATA),
    .oADDR_WR_0 (oADDR_WR_0),
    .oADDR_WR_1 (oADDR_WR_1),
    .oADDR_WR_2 (oADDR_WR_2),
    .oADDR_WR_3 (oADDR_WR_3),
    .oWE_0      (oWE_0),
    .oWE_1      (oWE_1),
    .oWE_2      (oWE_2),
    .oWE_3      (oWE_3),
    .oSTART     (oSTART),
    .oBUSY      (oBUSY),
    .oFRAME_CNT (oFRAME_CNT)
  );

  // Frame position of sample n in the core's RAM: index 0..2047, bank = idx mod 4, word = idx div 4.
  function automatic int unsigned ram_index(input int unsigned n);
`ifdef FFT_LOADER_BITREV_EN
    int unsigned r = 0;
    int unsigned x = n;
    for (int i = 0; i < 11; i++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
`else
    return n;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict any write, then check the write outputs of the next cycle.
  task automatic cycle(input logic v, input logic [15:0] s, input logic rdy);
    logic        acc;
    int unsigned idx;
    int unsigned bank;
    int unsigned addr;
    logic [3:0]  one;
    logic [3:0]  we_exp;
    logic [8:0]  addr_obs;
    iVALID   = v;
    iSAMPLE  = s;
    iFFT_RDY = rdy;
    acc  = v && (oREADY === 1'b1);
    idx  = ram_index(m_n);
    bank = idx % 4;
    addr = idx / 4;
    if (acc) m_n++;
    @(posedge iCLK);
    @(negedge iCLK);
    one    = 4'b0001;
    we_exp = acc ? (one << bank) : 4'b0000;
    chk("we_vec", {28'd0, oWE_3, oWE_2, oWE_1, oWE_0}, {28'd0, we_exp});
    if (acc) begin
      case (bank)
        0:       addr_obs = oADDR_WR_0;
        1:       addr_obs = oADDR_WR_1;
        2:       addr_obs = oADDR_WR_2;
        default: addr_obs = oADDR_WR_3;
      endcase
      chk("wr_addr", 32'(addr_obs), addr);
      chk("wr_data", 32'(oDATA), 32'(s));
    end
    if (oSTART === 1'b1) starts++;
  endtask

  // From the cycle after the final accept through completion, with iVALID held high.
  task automatic finish_frame();
    chk("flush_ready", 32'(oREADY), 0);
    chk("flush_start", 32'(oSTART), 0);
    cycle(1'b1, 16'hBEEF, 1'b0);
    chk("start_pulse", 32'(oSTART), 1);
    chk("start_busy", 32'(oBUSY), 1);
    cycle(1'b1, 16'hBEEF, 1'b1);
    chk("wait_start_low", 32'(oSTART), 0);
    chk("wait_rdy_early_ignored", 32'(oFRAME_CNT), 32'(frames));
    chk("wait_busy", 32'(oBUSY), 1);
    repeat (3) cycle(1'b1, 16'hBEEF, 1'b0);
    chk("wait_stalled", 32'(oREADY), 0);
    chk("wait_busy_hold", 32'(oBUSY), 1);
    cycle(1'b1, 16'hBEEF, 1'b1);
    frames++;
    m_n = 0;
    chk("done_busy", 32'(oBUSY), 0);
    chk("done_frame_cnt", 32'(oFRAME_CNT), 32'(frames));
    chk("done_ready_low", 32'(oREADY), 0);
    cycle(1'b1, 16'hBEEF, 1'b0);
    chk("idle_ready", 32'(oREADY), 1);
    chk("start_count", 32'(starts), 32'(frames));
  endtask

  initial begin
    // Reset state.
    iRESET = 1'b1;
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    chk("rst_ready", 32'(oREADY), 0);
    chk("rst_we", {28'd0, oWE_3, oWE_2, oWE_1, oWE_0}, 0);
    chk("rst_start_busy", {30'd0, oSTART, oBUSY}, 0);
    chk("rst_data", 32'(oDATA), 0);
    chk("rst_addr", {5'd0, oADDR_WR_3[2:0], oADDR_WR_2, oADDR_WR_1, oADDR_WR_0}, 0);
    chk("rst_frame", 32'(oFRAME_CNT), 0);
    iRESET = 1'b0;
    cycle(1'b0, 16'h0, 1'b0);
    chk("idle_ready_first", 32'(oREADY), 1);

    // Continuous frame, sample value = index.
    guard = 0;
    while (m_n < 2048 && guard < 4000) begin
      cycle(1'b1, 16'(m_n), 1'b0);
      guard++;
      if (m_n < 2048) chk("load_ready", 32'(oREADY), 1);
`ifdef FFT_LOADER_BITREV_EN
      if (m_n == 2) chk("brev_n1", {oWE_0, 22'd0, oADDR_WR_0}, {1'b1, 22'd0, 9'd256});
      if (m_n == 3) chk("brev_n2", {oWE_0, 22'd0, oADDR_WR_0}, {1'b1, 22'd0, 9'd128});
      if (m_n == 1025) chk("brev_n1024", {oWE_1, 22'd0, oADDR_WR_1}, {1'b1, 22'd0, 9'd0});
`else
      if (m_n == 6) chk("n5_write", {oWE_1, oDATA, 6'd0, oADDR_WR_1}, {1'b1, 16'd5, 6'd0, 9'd1});
`endif
    end
    chk("cont_fill", 32'(m_n), 2048);
    chk("last_write", {oWE_3, oDATA, 6'd0, oADDR_WR_3}, {1'b1, 16'd2047, 6'd0, 9'd511});
    finish_frame();

    // Gapped frame with random data; iFFT_RDY noise during load must be ignored.
    cycle(1'b1, 16'h5A5A, 1'b0);
    chk("after_wait_bank0", {oWE_0, 22'd0, oADDR_WR_0}, {1'b1, 22'd0, 9'd0});
    guard = 0;
    while (m_n < 2048 && guard < 12000) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
      guard++;
      if (m_n < 2048 && oBUSY !== 1'b0) chk("load_busy", 32'(oBUSY), 0);
    end
    chk("gap_fill", 32'(m_n), 2048);
    chk("gap_frame_cnt", 32'(oFRAME_CNT), 32'(frames));
    chk("gap_starts", 32'(starts), 32'(frames));
    finish_frame();

    // Reset in the middle of a frame.
    guard = 0;
    while (m_n < 700 && guard < 4000) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
      guard++;
    end
    chk("mid_fill", 32'(m_n), 700);
    iRESET = 1'b1;
    iVALID = 1'b1;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    chk("mid_rst_out", {oREADY, oSTART, oBUSY, oWE_3, oWE_2, oWE_1, oWE_0, 9'd0, oDATA}, 0);
    chk("mid_rst_addr", {5'd0, oADDR_WR_3[2:0], oADDR_WR_2, oADDR_WR_1, oADDR_WR_0}, 0);
    chk("mid_rst_frame", 32'(oFRAME_CNT), 0);
    iRESET = 1'b0;
    m_n = 0;
    cycle(1'b1, 16'h1234, 1'b0);
    chk("post_rst_ready", 32'(oREADY), 1);
    cycle(1'b1, 16'h1234, 1'b0);
    chk("post_rst_bank0", {oWE_0, oDATA, 6'd0, oADDR_WR_0}, {1'b1, 16'h1234, 6'd0, 9'd0});
    chk("post_rst_frame", 32'(oFRAME_CNT), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
